// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b - bin.
// One result bit per clock, LSB first, with a single registered borrow.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_valid/start_ready  operand handshake (a, b, bin); ready only in IDLE
//   a, b, bin                minuend, subtrahend, borrow in
//   diff, bout               result modulo 2^WIDTH, borrow out
//   overflow, zero           signed overflow flag, diff == 0 flag
//   done_valid/done_ready    result handshake; result held under backpressure
//   busy                     operation in flight (RUN or DONE)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic             zero,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic               borrow_q, borrow_d;
    logic               a_sign_q, a_sign_d;
    logic               b_sign_q, b_sign_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               bout_q,   bout_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;

    // Full-subtractor cell on the current LSBs
    logic               d_bit;
    logic               borrow_nxt;
    logic [WIDTH-1:0]   res_nxt;

    always_comb begin
        d_bit      = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
        borrow_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
        res_nxt    = {d_bit, res_q[WIDTH-1:1]};
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = bin;
                    a_sign_d = a[WIDTH-1];
                    b_sign_d = b[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = res_nxt;
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last bit: publish result and flags on the same edge
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = res_nxt;
                    bout_d  = borrow_nxt;
                    ovf_d   = (a_sign_q != b_sign_q) && (res_nxt[WIDTH-1] != a_sign_q);
                    zero_d  = (res_nxt == '0);
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Handshake and status decode straight from the state register
    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);

    assign diff     = diff_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
